// File: rtl/regfile_writeback_unit_pkg.sv
// Shared definitions for the register-file write-back path: register
// geometry, the architectural zero register and the queued-write entry.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_ZERO   = 0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_unit_if.sv
// Result-delivery bundle between the execution units (ALU, LSU) and the
// write-back buffer. The producers are the master side.
interface regfile_writeback_unit_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_dest;
    logic [DATA_W-1:0] lsu_data;
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_dest;
    logic [DATA_W-1:0] alu_data;

    modport master (
        output lsu_valid, lsu_dest, lsu_data,
        output alu_valid, alu_dest, alu_data,
        input  lsu_ready, alu_ready
    );

    modport slave (
        input  lsu_valid, lsu_dest, lsu_data,
        input  alu_valid, alu_dest, alu_data,
        output lsu_ready, alu_ready
    );
endinterface

// File: rtl/regfile_writeback_unit_fifo.sv
// In-order circular buffer with two ordered push lanes (lane 0 is older),
// one pop, and an age-ordered view of every slot for associative search.
module regfile_writeback_unit_fifo
    import regfile_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push0_en_i,
    input  entry_t                 push0_entry_i,
    input  logic                   push1_en_i,
    input  entry_t                 push1_entry_i,
    input  logic                   pop_en_i,
    output entry_t                 head_o,
    output logic [CNT_W-1:0]       count_o,
    output entry_t [DEPTH-1:0]     ord_o,
    output logic   [DEPTH-1:0]     vld_o
);

    entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   wr_ptr1_s;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         n_push_s;

    // Next pointers and occupancy; the second lane lands right after the first.
    always_comb begin
        n_push_s  = {1'b0, push0_en_i} + {1'b0, push1_en_i};
        wr_ptr1_s = wr_ptr_q + PTR_W'(push0_en_i);
        wr_ptr_d  = wr_ptr_q + PTR_W'(n_push_s);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop_en_i);
        count_d   = count_q + CNT_W'(n_push_s) - CNT_W'(pop_en_i);
    end

    // Storage and pointer state; reset discards every queued entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push0_en_i) begin
                mem_q[wr_ptr_q] <= push0_entry_i;
            end else begin
                mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
            end
            if (push1_en_i) begin
                mem_q[wr_ptr1_s] <= push1_entry_i;
            end else begin
                mem_q[wr_ptr1_s] <= mem_q[wr_ptr1_s];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Age-ordered view: slot 0 is the head (oldest), higher slots are younger.
    always_comb begin
        ord_o = '0;
        vld_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ord_o[i] = mem_q[rd_ptr_q + PTR_W'(i)];
            vld_o[i] = (CNT_W'(i) < count_q);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/regfile_writeback_unit.sv
// Write-back unit: queues ALU/LSU results in program order, drains one per
// cycle into the register file and forwards pending values to decode.
module regfile_writeback_unit
    import regfile_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter int  DATA_W = REG_DATA_W,
    parameter int  ADDR_W = REG_ADDR_W,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    regfile_writeback_unit_if.slave  res_if,
    input  logic                     wb_stall,
    output logic                     reg_write_en,
    output logic [ADDR_W-1:0]        reg_write_dest,
    output logic [DATA_W-1:0]        reg_write_data,
    input  logic [ADDR_W-1:0]        fwd_addr_1,
    output logic                     fwd_hit_1,
    output logic [DATA_W-1:0]        fwd_data_1,
    input  logic [ADDR_W-1:0]        fwd_addr_2,
    output logic                     fwd_hit_2,
    output logic [DATA_W-1:0]        fwd_data_2,
    output logic [CNT_W-1:0]         pending_cnt
);

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t               lsu_entry_s, alu_entry_s, push0_entry_s, head_s;
    entry_t [DEPTH-1:0]   ord_s;
    logic   [DEPTH-1:0]   vld_s;
    logic   [CNT_W-1:0]   count_s;
    logic                 lsu_store_s, alu_store_s, push0_en_s, push1_en_s, pop_s;
    logic   [DATA_W:0]    fwd1_s, fwd2_s;

    // Youngest pending write to addr wins; register 0 is never forwarded.
    function automatic logic [DATA_W:0] fwd_search(
        input logic [ADDR_W-1:0] addr,
        input entry_t [DEPTH-1:0] ord,
        input logic [DEPTH-1:0]   vld
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && (ord[i].dest == addr) && (addr != ADDR_W'(REG_ZERO))) begin
                res = {1'b1, ord[i].data};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Handshakes, push-lane steering and drain; ready ignores the drain on purpose.
    always_comb begin
        res_if.lsu_ready = (count_s < CNT_W'(DEPTH));
        res_if.alu_ready = (count_s < CNT_W'(DEPTH - 1)) ||
                           ((count_s < CNT_W'(DEPTH)) && !res_if.lsu_valid);
        lsu_entry_s   = '{dest: res_if.lsu_dest, data: res_if.lsu_data};
        alu_entry_s   = '{dest: res_if.alu_dest, data: res_if.alu_data};
        // Writes to register 0 complete the handshake but are dropped here.
        lsu_store_s   = res_if.lsu_valid && res_if.lsu_ready &&
                        (res_if.lsu_dest != ADDR_W'(REG_ZERO));
        alu_store_s   = res_if.alu_valid && res_if.alu_ready &&
                        (res_if.alu_dest != ADDR_W'(REG_ZERO));
        push0_en_s    = lsu_store_s || alu_store_s;
        push1_en_s    = lsu_store_s && alu_store_s;
        push0_entry_s = lsu_store_s ? lsu_entry_s : alu_entry_s;
        pop_s         = (count_s != CNT_W'(0)) && !wb_stall;
    end

    regfile_writeback_unit_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push0_en_i    (push0_en_s),
        .push0_entry_i (push0_entry_s),
        .push1_en_i    (push1_en_s),
        .push1_entry_i (alu_entry_s),
        .pop_en_i      (pop_s),
        .head_o        (head_s),
        .count_o       (count_s),
        .ord_o         (ord_s),
        .vld_o         (vld_s)
    );

    // Register-file write port and forwarding lookups, all from buffer state.
    always_comb begin
        reg_write_en   = pop_s;
        reg_write_dest = pop_s ? head_s.dest : '0;
        reg_write_data = pop_s ? head_s.data : '0;
        fwd1_s         = fwd_search(fwd_addr_1, ord_s, vld_s);
        fwd2_s         = fwd_search(fwd_addr_2, ord_s, vld_s);
        fwd_hit_1      = fwd1_s[DATA_W];
        fwd_data_1     = fwd1_s[DATA_W-1:0];
        fwd_hit_2      = fwd2_s[DATA_W];
        fwd_data_2     = fwd2_s[DATA_W-1:0];
        pending_cnt    = count_s;
    end

endmodule
